// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the 7-segment driver.
// The result is held between conversions, so the display never shows partial digits.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  // One guard digit above the output digits keeps oversized inputs out of the low digits.
  localparam int SW = 4*DIGITS + 4;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  localparam int unsigned MAXV = pow10(DIGITS) - 32'd1;

  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [BIN_W-1:0]     shift_r, shift_s;
  logic [SW-1:0]        scratch_r, scratch_s;
  logic [SW-1:0]        adj_s;
  logic [CW-1:0]        count_r, count_s;
  logic                 ovf_pend_r, ovf_pend_s;
  logic [4*DIGITS-1:0]  bcd_r, bcd_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 ovf_r, ovf_s;

  assign adj_s = add3(scratch_r);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= {BIN_W{1'b0}};
      scratch_r  <= {SW{1'b0}};
      count_r    <= {CW{1'b0}};
      ovf_pend_r <= 1'b0;
      bcd_r      <= {(4*DIGITS){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      scratch_r  <= scratch_s;
      count_r    <= count_s;
      ovf_pend_r <= ovf_pend_s;
      bcd_r      <= bcd_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      ovf_r      <= ovf_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    scratch_s  = scratch_r;
    count_s    = count_r;
    ovf_pend_s = ovf_pend_r;
    bcd_s      = bcd_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    ovf_s      = ovf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          shift_s    = bin;
          scratch_s  = {SW{1'b0}};
          count_s    = {CW{1'b0}};
          ovf_pend_s = (32'(bin) > MAXV);
          busy_s     = 1'b1;
          state_s    = SHIFT;
        end else begin
          state_s    = IDLE;
        end
      end
      SHIFT: begin
        // Correction is applied to the current scratch, then the whole pair shifts.
        {scratch_s, shift_s} = {adj_s, shift_r} << 1;
        count_s = count_r + CW'(1);
        if (count_r == CW'(BIN_W - 1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (ovf_pend_r) begin
          bcd_s = {DIGITS{4'h9}};
        end else begin
          bcd_s = scratch_r[4*DIGITS-1:0];
        end
        ovf_s   = ovf_pend_r;
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bcd  = bcd_r;
  assign busy = busy_r;
  assign done = done_r;
  assign ovf  = ovf_r;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the 7-segment display driver. Its packed 4-digit BCD output feeds the driver's 16-bit `num` input.
- Converts a binary value into thousands/hundreds/tens/units nibbles over multiple cycles, using a start/done handshake.
- Holds the last result stable between conversions, so the multiplexed display never shows intermediate values.

Parameters:
- BIN_W, 14, width of binary input. Legal range 4..4*DIGITS.
- DIGITS, 4, number of BCD digits produced. Output width is 4*DIGITS.

Ports:
- clk  in  1  system clock. All logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- bin  in  BIN_W  unsigned binary value. Sampled only on the accepting edge.
- start  in  1  conversion request. Level-sampled each edge.
- bcd  out  4*DIGITS  packed BCD result. [4*DIGITS-1 -: 4] is the most significant digit; [3:0] is units.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd has just been updated.
- ovf  out  1  bin exceeded 10^DIGITS-1 on the last completed conversion.

Behaviour:
- One clock domain. Reset is synchronous and active-high, on ports named clk and rst.
- Reset values: bcd=0, busy=0, done=0, ovf=0, state=IDLE, internal counter and scratch registers = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: latch bin into the shift register, clear the BCD scratch, set count=0.
  - Latch ovf_pend = (bin > 10^DIGITS-1). Set busy=1 and go to SHIFT.
  - With start=0: stay in IDLE.
- SHIFT, each edge:
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, shift reg} shifts left by 1 and count increments.
  - The edge performing shift number BIN_W (count == BIN_W-1) moves to DONE.
  - Add-3 and shift are done in the same cycle: the correction is combinational on the current scratch before the shift.
- DONE, single edge:
  - bcd <= ovf_pend ? all digits 9 : low 4*DIGITS bits of scratch.
  - ovf <= ovf_pend, done <= 1, busy <= 0, go to IDLE.
- done is high for exactly one cycle, the cycle after the DONE edge. It deasserts on the next edge unconditionally.
- Scratch width is 4*DIGITS+4 bits (one guard digit). This keeps values above 10^DIGITS-1 from corrupting the lower digits. The guard digit is never output.
- Latency: if start is sampled on edge E0, bcd/done/ovf update on edge E0+BIN_W+1. Default: 15 cycles.
- busy is high from edge E0+1 through edge E0+BIN_W+1, then low.
- Throughput: start is ignored in SHIFT and DONE, with no queueing. It is accepted on the first IDLE edge, which may be the cycle where done=1. Back-to-back conversion period is BIN_W+2 cycles.
- bcd and ovf change only on the DONE edge or on reset. They hold between conversions, and bin changes while busy have no effect.
- Reset mid-conversion: the same edge aborts to IDLE and clears all outputs. No done pulse is produced for the aborted request.
- rst and start on the same edge: rst wins and start is dropped.
- bin=0 is a normal conversion, giving bcd=0 after full latency. No early exit.

Test Plan:
- Reset, then bin=14'd1234, start for 1 cycle -> busy=1 on the next cycle; done=1 exactly 15 cycles after the start edge; bcd=16'h1234, ovf=0; busy=0 in the done cycle.
- bin=9999 -> bcd=16'h9999, ovf=0. Then bin=0 -> bcd=16'h0000 after 15 cycles, ovf=0, done pulses once.
- bin=10000, then bin=16383 (max) -> each gives bcd=16'h9999, ovf=1. A following bin=42 gives bcd=16'h0042, ovf=0.
- Start with bin=567. Assert start again with bin=890 at cycles 3 and 14 of the conversion -> only one done, bcd=16'h0567. A start held on the done cycle is accepted: 16 cycles later bcd=16'h0890.
- Start bin=4321. Assert rst at cycle 7 for 1 cycle -> next cycle bcd=0, busy=0, done=0, and done never pulses for 4321. A new start with bin=8 gives bcd=16'h0008.
- Exhaustive sweep bin=0..16383 against a reference model (decimal digits, or 9999 plus ovf when above 9999) -> all match. bcd is stable while busy.
